imem_port_arbiter: RTL and testbench

//  Owns the single synchronous-read port of the instruction BRAM and shares it between the core's fetch

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_port_arbiter.sv | 102 ++++++++++
 tb/tb_imem_port_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and sizing helpers for the instruction memory port arbiter
`timescale 1ns/1ps
package imem_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_RESUME = 2'd3
  } imem_state_t;

  localparam int INST_DEPTH_DEFAULT = 256;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - shares the single instruction BRAM port between core fetch and program loader
`timescale 1ns/1ps
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int INST_DEPTH = INST_DEPTH_DEFAULT,
  localparam int AW = addr_width(INST_DEPTH)
) (
  input  logic          clk,
  input  logic          resetpc,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [31:0]   fetch_inst,
  input  logic          ld_mode,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic          ld_ready,
  output logic          cpu_stall,
  output logic          cpu_pcrst,
  output logic [AW:0]   ld_count,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [AW:0] CNT_MAX = (AW+1)'(INST_DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  imem_state_t state_q, state_d;
  logic        fetch_rvalid_q, fetch_rvalid_d;
  logic [AW:0] ld_count_q, ld_count_d;

  always_ff @(posedge clk or posedge resetpc) begin
    if (resetpc) begin
      state_q        <= ST_RUN;
      fetch_rvalid_q <= 1'b0;
      ld_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      fetch_rvalid_q <= fetch_rvalid_d;
      ld_count_q     <= ld_count_d;
    end
  end

  // Port mux is purely a function of state; reset also forces every strobe low.
  always_comb begin
    state_d    = state_q;
    ld_count_d = ld_count_q;
    fetch_gnt  = 1'b0;
    ld_ready   = 1'b0;
    cpu_stall  = 1'b0;
    cpu_pcrst  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (!resetpc) begin
      case (state_q)
        ST_RUN: begin
          fetch_gnt = fetch_req;
          mem_en    = fetch_req;
          mem_addr  = fetch_addr;
          if (ld_mode) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          cpu_stall  = 1'b1;
          ld_count_d = '0;
          state_d    = ST_LOAD;
        end
        ST_LOAD: begin
          cpu_stall = 1'b1;
          ld_ready  = 1'b1;
          if (ld_valid) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_data;
            if (ld_count_q != CNT_MAX) ld_count_d = ld_count_q + CNT_ONE;
          end
          if (!ld_mode) state_d = ST_RESUME;
        end
        ST_RESUME: begin
          cpu_stall = 1'b1;
          cpu_pcrst = 1'b1;
          state_d   = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  assign fetch_rvalid_d = fetch_gnt;
  assign fetch_rvalid   = fetch_rvalid_q;
  assign fetch_inst     = fetch_rvalid_q ? mem_rdata : 32'h0;
  assign ld_count       = ld_count_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - directed self-checking bench for imem_port_arbiter with a BRAM model
`timescale 1ns/1ps
module tb_imem_port_arbiter;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          resetpc;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt;
  logic          fetch_rvalid;
  logic [31:0]   fetch_inst;
  logic          ld_mode;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          ld_ready;
  logic          cpu_stall;
  logic          cpu_pcrst;
  logic [AW:0]   ld_count;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] bram [256];

  imem_port_arbiter #(.INST_DEPTH(256)) dut (
    .clk(clk), .resetpc(resetpc),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_inst(fetch_inst),
    .ld_mode(ld_mode), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .cpu_stall(cpu_stall), .cpu_pcrst(cpu_pcrst), .ld_count(ld_count),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) bram[i] = 32'hA000_0000 + i;
    mem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bram[mem_addr];
    end
  end

  task automatic test_reset;
    resetpc = 1'b1; fetch_req = 1'b1; fetch_addr = '0;
    ld_mode = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    @(negedge clk); #1;
    if (fetch_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_gnt got %h exp 0", fetch_gnt); end n_cmp++;
    if (fetch_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid got %h exp 0", fetch_rvalid); end n_cmp++;
    if (fetch_inst !== 32'h0) begin n_bad++; $display("FAIL rst_inst got %h exp 0", fetch_inst); end n_cmp++;
    if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %h exp 0", cpu_stall); end n_cmp++;
    if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %h exp 0", ld_ready); end n_cmp++;
    if (ld_count !== 9'd0) begin n_bad++; $display("FAIL rst_count got %h exp 0", ld_count); end n_cmp++;
    if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en got %h exp 0", mem_en); end n_cmp++;
    if (cpu_pcrst !== 1'b0) begin n_bad++; $display("FAIL rst_pcrst got %h exp 0", cpu_pcrst); end n_cmp++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk); resetpc = 1'b0; fetch_req = 1'b1; fetch_addr = 8'd0; #1;
    if (fetch_gnt !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt0 got %h exp 1", fetch_gnt); end n_cmp++;
    if (mem_addr !== 8'd0) begin n_bad++; $display("FAIL b2b_addr0 got %h exp 0", mem_addr); end n_cmp++;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); fetch_addr = AW'(k); #1;
      if (fetch_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0) begin n_bad++; $display("FAIL b2b_gnt%0d got gnt=%h en=%h we=%h exp 1 1 0", k, fetch_gnt, mem_en, mem_we); end n_cmp++;
      if (mem_addr !== AW'(k)) begin n_bad++; $display("FAIL b2b_addr%0d got %h exp %h", k, mem_addr, k); end n_cmp++;
      if (fetch_rvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_rvalid%0d got %h exp 1", k, fetch_rvalid); end n_cmp++;
      if (fetch_inst !== 32'hA000_0000 + k - 1) begin n_bad++; $display("FAIL b2b_inst%0d got %h exp %h", k, fetch_inst, 32'hA000_0000 + k - 1); end n_cmp++;
    end
    @(negedge clk); fetch_req = 1'b0; #1;
    if (fetch_gnt !== 1'b0) begin n_bad++; $display("FAIL b2b_gnt_idle got %h exp 0", fetch_gnt); end n_cmp++;
    if (fetch_inst !== 32'hA000_0003) begin n_bad++; $display("FAIL b2b_inst3 got %h exp a0000003", fetch_inst); end n_cmp++;
    @(negedge clk); #1;
    if (fetch_rvalid !== 1'b0 || fetch_inst !== 32'h0) begin n_bad++; $display("FAIL b2b_quiet got rvalid=%h inst=%h exp 0 0", fetch_rvalid, fetch_inst); end n_cmp++;
  endtask

  task automatic test_enter_load;
    @(negedge clk); fetch_req = 1'b1; fetch_addr = 8'd5; ld_mode = 1'b1; #1;
    if (fetch_gnt !== 1'b1) begin n_bad++; $display("FAIL drain_last_gnt got %h exp 1", fetch_gnt); end n_cmp++;
    if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL drain_early_stall got %h exp 0", cpu_stall); end n_cmp++;
    @(negedge clk); #1;
    if (fetch_gnt !== 1'b0 || mem_en !== 1'b0) begin n_bad++; $display("FAIL drain_no_gnt got gnt=%h en=%h exp 0 0", fetch_gnt, mem_en); end n_cmp++;
    if (cpu_stall !== 1'b1 || ld_ready !== 1'b0) begin n_bad++; $display("FAIL drain_stall got stall=%h ready=%h exp 1 0", cpu_stall, ld_ready); end n_cmp++;
    if (fetch_rvalid !== 1'b1 || fetch_inst !== 32'hA000_0005) begin n_bad++; $display("FAIL drain_return got rvalid=%h inst=%h exp 1 a0000005", fetch_rvalid, fetch_inst); end n_cmp++;
    @(negedge clk); fetch_req = 1'b0; #1;
    if (ld_ready !== 1'b1 || cpu_stall !== 1'b1) begin n_bad++; $display("FAIL load_ready got ready=%h stall=%h exp 1 1", ld_ready, cpu_stall); end n_cmp++;
    if (fetch_rvalid !== 1'b0 || ld_count !== 9'd0) begin n_bad++; $display("FAIL load_entry got rvalid=%h count=%h exp 0 0", fetch_rvalid, ld_count); end n_cmp++;
  endtask

  task automatic test_load_write;
    @(negedge clk); ld_valid = 1'b1; ld_addr = 8'd0; ld_data = 32'h2008_0005; #1;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'd0 || mem_wdata !== 32'h2008_0005) begin n_bad++; $display("FAIL wr0 got en=%h we=%h addr=%h data=%h exp 1 1 00 20080005", mem_en, mem_we, mem_addr, mem_wdata); end n_cmp++;
    @(negedge clk); ld_addr = 8'd1; ld_data = 32'h2009_000A; #1;
    if (mem_we !== 1'b1 || mem_wdata !== 32'h2009_000A) begin n_bad++; $display("FAIL wr1 got we=%h data=%h exp 1 2009000a", mem_we, mem_wdata); end n_cmp++;
    if (ld_count !== 9'd1) begin n_bad++; $display("FAIL wr_count1 got %h exp 1", ld_count); end n_cmp++;
    @(negedge clk); ld_valid = 1'b0; ld_mode = 1'b0; #1;
    if (ld_count !== 9'd2 || mem_en !== 1'b0) begin n_bad++; $display("FAIL wr_count2 got count=%h en=%h exp 2 0", ld_count, mem_en); end n_cmp++;
    if (cpu_pcrst !== 1'b0) begin n_bad++; $display("FAIL load_pcrst got %h exp 0", cpu_pcrst); end n_cmp++;
    @(negedge clk); #1;
    if (cpu_pcrst !== 1'b1 || cpu_stall !== 1'b1 || ld_ready !== 1'b0 || mem_en !== 1'b0) begin n_bad++; $display("FAIL resume got pcrst=%h stall=%h ready=%h en=%h exp 1 1 0 0", cpu_pcrst, cpu_stall, ld_ready, mem_en); end n_cmp++;
    @(negedge clk); #1;
    if (cpu_pcrst !== 1'b0 || cpu_stall !== 1'b0) begin n_bad++; $display("FAIL back_to_run got pcrst=%h stall=%h exp 0 0", cpu_pcrst, cpu_stall); end n_cmp++;
    if (ld_count !== 9'd2) begin n_bad++; $display("FAIL count_hold got %h exp 2", ld_count); end n_cmp++;
  endtask

  task automatic test_reload_fetch;
    @(negedge clk); fetch_req = 1'b1; fetch_addr = 8'd0; #1;
    if (fetch_gnt !== 1'b1) begin n_bad++; $display("FAIL reload_gnt got %h exp 1", fetch_gnt); end n_cmp++;
    @(negedge clk); fetch_addr = 8'd1; #1;
    if (fetch_inst !== 32'h2008_0005) begin n_bad++; $display("FAIL reload_inst0 got %h exp 20080005", fetch_inst); end n_cmp++;
    @(negedge clk); fetch_req = 1'b0; #1;
    if (fetch_inst !== 32'h2009_000A) begin n_bad++; $display("FAIL reload_inst1 got %h exp 2009000a", fetch_inst); end n_cmp++;
  endtask

  task automatic test_ld_pulse;
    @(negedge clk); ld_mode = 1'b1; #1;
    if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL pulse_run got stall=%h exp 0", cpu_stall); end n_cmp++;
    @(negedge clk); ld_mode = 1'b0; #1;
    if (cpu_stall !== 1'b1 || ld_ready !== 1'b0 || cpu_pcrst !== 1'b0) begin n_bad++; $display("FAIL pulse_drain got stall=%h ready=%h pcrst=%h exp 1 0 0", cpu_stall, ld_ready, cpu_pcrst); end n_cmp++;
    @(negedge clk); #1;
    if (ld_ready !== 1'b1 || ld_count !== 9'd0) begin n_bad++; $display("FAIL pulse_load got ready=%h count=%h exp 1 0", ld_ready, ld_count); end n_cmp++;
    @(negedge clk); #1;
    if (cpu_pcrst !== 1'b1) begin n_bad++; $display("FAIL pulse_resume got pcrst=%h exp 1", cpu_pcrst); end n_cmp++;
    @(negedge clk); #1;
    if (cpu_pcrst !== 1'b0 || cpu_stall !== 1'b0) begin n_bad++; $display("FAIL pulse_run_again got pcrst=%h stall=%h exp 0 0", cpu_pcrst, cpu_stall); end n_cmp++;
  endtask

  task automatic test_saturate;
    @(negedge clk); ld_mode = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 259; i++) begin
      @(negedge clk); ld_valid = 1'b1; ld_addr = i[7:0]; ld_data = 32'hB000_0000 + i; #1;
      if (i == 256 && ld_count !== 9'd256) begin n_bad++; $display("FAIL sat_mid got %h exp 100", ld_count); end
      if (i == 256) n_cmp++;
      if (i == 258 && (mem_addr !== 8'd2 || mem_we !== 1'b1)) begin n_bad++; $display("FAIL sat_wrap got addr=%h we=%h exp 02 1", mem_addr, mem_we); end
      if (i == 258) n_cmp++;
    end
    @(negedge clk); ld_valid = 1'b0; ld_mode = 1'b0; #1;
    if (ld_count !== 9'd256) begin n_bad++; $display("FAIL sat_final got %h exp 100", ld_count); end n_cmp++;
    @(negedge clk);
    @(negedge clk); ld_valid = 1'b1; ld_addr = 8'd7; ld_data = 32'hDEAD_BEEF; #1;
    if (mem_we !== 1'b0 || mem_en !== 1'b0 || ld_ready !== 1'b0) begin n_bad++; $display("FAIL run_ignore_ld got we=%h en=%h ready=%h exp 0 0 0", mem_we, mem_en, ld_ready); end n_cmp++;
    @(negedge clk); ld_valid = 1'b0; fetch_req = 1'b1; fetch_addr = 8'd0;
    @(negedge clk); fetch_addr = 8'd3; #1;
    if (fetch_inst !== 32'hB000_0100) begin n_bad++; $display("FAIL sat_wrap_data got %h exp b0000100", fetch_inst); end n_cmp++;
    @(negedge clk); fetch_addr = 8'd7; #1;
    if (fetch_inst !== 32'hB000_0003) begin n_bad++; $display("FAIL sat_word3 got %h exp b0000003", fetch_inst); end n_cmp++;
    @(negedge clk); fetch_req = 1'b0; #1;
    if (fetch_inst !== 32'hB000_0007) begin n_bad++; $display("FAIL run_write_blocked got %h exp b0000007", fetch_inst); end n_cmp++;
  endtask

  task automatic test_reset_mid_load;
    @(negedge clk); ld_mode = 1'b1;
    @(negedge clk);
    @(negedge clk); ld_valid = 1'b1; ld_addr = 8'd9; ld_data = 32'hC0FF_EE00; #1;
    if (mem_we !== 1'b1) begin n_bad++; $display("FAIL mid_wr got we=%h exp 1", mem_we); end n_cmp++;
    @(negedge clk); ld_valid = 1'b0; #1;
    if (ld_count !== 9'd1) begin n_bad++; $display("FAIL mid_count got %h exp 1", ld_count); end n_cmp++;
    #1 resetpc = 1'b1; ld_mode = 1'b0; #1;
    if (cpu_stall !== 1'b0 || ld_ready !== 1'b0 || ld_count !== 9'd0 || cpu_pcrst !== 1'b0 || mem_en !== 1'b0) begin n_bad++; $display("FAIL mid_async got stall=%h ready=%h count=%h pcrst=%h en=%h exp all 0", cpu_stall, ld_ready, ld_count, cpu_pcrst, mem_en); end n_cmp++;
    @(negedge clk); resetpc = 1'b0; fetch_req = 1'b1; fetch_addr = 8'd9; #1;
    if (fetch_gnt !== 1'b1 || cpu_pcrst !== 1'b0 || cpu_stall !== 1'b0) begin n_bad++; $display("FAIL mid_run got gnt=%h pcrst=%h stall=%h exp 1 0 0", fetch_gnt, cpu_pcrst, cpu_stall); end n_cmp++;
    @(negedge clk); fetch_req = 1'b0; #1;
    if (fetch_rvalid !== 1'b1 || fetch_inst !== 32'hC0FF_EE00) begin n_bad++; $display("FAIL mid_kept got rvalid=%h inst=%h exp 1 c0ffee00", fetch_rvalid, fetch_inst); end n_cmp++;
    @(negedge clk); #1;
    if (cpu_pcrst !== 1'b0) begin n_bad++; $display("FAIL mid_no_pcrst got %h exp 0", cpu_pcrst); end n_cmp++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_enter_load();
    test_load_write();
    test_reload_fetch();
    test_ld_pulse();
    test_saturate();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
